// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the IF/MEM memory arbiter: FSM states, me_len
// encodings and the stall request levels used by the stall controller.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        MaStateIdle,
        MaStateRd,
        MaStateWr,
        MaStateDone
    } ma_state_e;

    localparam logic [1:0] MemLenByte = 2'd0;
    localparam logic [1:0] MemLenHalf = 2'd1;
    localparam logic [1:0] MemLenWord = 2'd3;

    localparam logic StallReq   = 1'b1;
    localparam logic NoStallReq = 1'b0;

    // Byte count for a MEM access; the illegal encoding 2 is treated as a word.
    function automatic logic [2:0] len_to_n(input logic [1:0] len);
        case (len)
            MemLenByte: len_to_n = 3'd1;
            MemLenHalf: len_to_n = 3'd2;
            MemLenWord: len_to_n = 3'd4;
            default:    len_to_n = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_grant.sv
// Combinational winner select between IF and MEM requests.
// MEMCTRL_RR_EN selects round-robin on ties; otherwise MEM always wins.
module mem_grant (
    input  logic if_req,
    input  logic me_req,
    input  logic last_me,
    output logic gnt_me
);

`ifdef MEMCTRL_RR_EN
    // On a tie, serve whoever was not served by the last completed access.
    assign gnt_me = (if_req && me_req) ? !last_me : me_req;
`else
    logic unused_grant_in;
    assign unused_grant_in = if_req ^ last_me;
    assign gnt_me          = me_req;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between IF and MEM; serialises 1/2/4-byte accesses onto a byte-wide port.
// Define MEMCTRL_RR_EN for round-robin arbitration (default build: fixed priority, MEM over IF).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              me_req,
    input  logic              me_we,
    input  logic [ADDR_W-1:0] me_addr,
    input  logic [1:0]        me_len,
    input  logic [31:0]       me_wdata,
    output logic              me_done,
    output logic [31:0]       me_rdata,
    output logic              if_stall_req,
    output logic              me_stall_req,
    output logic [ADDR_W-1:0] mem_a,
    output logic [7:0]        mem_dout,
    input  logic [7:0]        mem_din,
    output logic              mem_wr
);

    ma_state_e         state;
    logic [2:0]        cnt;
    logic [2:0]        n_bytes;
    logic              gnt;
    logic              last_me;
    logic [ADDR_W-1:0] base;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;

    logic              gnt_me;
    logic [ADDR_W-1:0] req_addr;
    logic [2:0]        cnt_nx;
    logic [1:0]        cap_idx;
    logic [31:0]       rd_next;

    mem_grant u_grant (
        .if_req  (if_req),
        .me_req  (me_req),
        .last_me (last_me),
        .gnt_me  (gnt_me)
    );

    assign req_addr = gnt_me ? me_addr : if_addr;
    assign cnt_nx   = cnt + 3'd1;
    // Byte returned this cycle belongs to the address driven at cnt-1 (cnt = 1..4).
    assign cap_idx  = cnt[1:0] - 2'd1;

    always_comb begin
        rd_next = rdata_q;
        if (state == MaStateRd && cnt != 3'd0) begin
            rd_next[{cap_idx, 3'b000} +: 8] = mem_din;
        end
    end

    assign if_stall_req = (if_req && !if_done) ? StallReq : NoStallReq;
    assign me_stall_req = (me_req && !me_done) ? StallReq : NoStallReq;

    // RAM-side outputs are registered one cycle ahead of the byte they address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= MaStateIdle;
            cnt      <= 3'd0;
            n_bytes  <= 3'd0;
            gnt      <= 1'b0;
            last_me  <= 1'b0;
            base     <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            if_done  <= 1'b0;
            me_done  <= 1'b0;
            if_data  <= '0;
            me_rdata <= '0;
            mem_a    <= '0;
            mem_dout <= '0;
            mem_wr   <= 1'b0;
        end else begin
            if_done  <= 1'b0;
            me_done  <= 1'b0;
            if_data  <= '0;
            me_rdata <= '0;
            unique case (state)
                MaStateIdle: begin
                    if (if_req || me_req) begin
                        gnt     <= gnt_me;
                        base    <= req_addr;
                        n_bytes <= gnt_me ? len_to_n(me_len) : 3'd4;
                        wdata_q <= me_wdata;
                        rdata_q <= '0;
                        cnt     <= 3'd0;
                        mem_a   <= req_addr;
                        if (gnt_me && me_we) begin
                            state    <= MaStateWr;
                            mem_wr   <= 1'b1;
                            mem_dout <= me_wdata[7:0];
                        end else begin
                            state <= MaStateRd;
                        end
                    end
                end
                MaStateRd: begin
                    rdata_q <= rd_next;
                    cnt     <= cnt_nx;
                    mem_a   <= (cnt_nx < n_bytes) ? base + ADDR_W'(cnt_nx) : '0;
                    if (cnt == n_bytes) begin
                        state <= MaStateDone;
                        if (gnt) begin
                            me_done  <= 1'b1;
                            me_rdata <= rd_next;
                        end else begin
                            if_done <= 1'b1;
                            if_data <= rd_next;
                        end
                    end
                end
                MaStateWr: begin
                    cnt <= cnt_nx;
                    if (cnt_nx == n_bytes) begin
                        state    <= MaStateDone;
                        me_done  <= 1'b1;
                        mem_a    <= '0;
                        mem_dout <= '0;
                        mem_wr   <= 1'b0;
                    end else begin
                        mem_a    <= base + ADDR_W'(cnt_nx);
                        mem_dout <= wdata_q[{cnt_nx[1:0], 3'b000} +: 8];
                    end
                end
                MaStateDone: begin
                    state   <= MaStateIdle;
                    last_me <= gnt;
                end
                default: state <= MaStateIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table plus hand-written contention and
// reset-abort sequences, with a scoreboard matching done pulses to expected results.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        me_req;
    logic        me_we;
    logic [31:0] me_addr;
    logic [1:0]  me_len;
    logic [31:0] me_wdata;
    logic        me_done;
    logic [31:0] me_rdata;
    logic        if_stall_req;
    logic        me_stall_req;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        mem_wr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_done      (if_done),
        .if_data      (if_data),
        .me_req       (me_req),
        .me_we        (me_we),
        .me_addr      (me_addr),
        .me_len       (me_len),
        .me_wdata     (me_wdata),
        .me_done      (me_done),
        .me_rdata     (me_rdata),
        .if_stall_req (if_stall_req),
        .me_stall_req (me_stall_req),
        .mem_a        (mem_a),
        .mem_dout     (mem_dout),
        .mem_din      (mem_din),
        .mem_wr       (mem_wr)
    );

    // RAM model: byte array folded onto a 64K window, read data one cycle after address.
    logic [7:0]  ram [65536];
    logic        pl_en = 1'b0;
    logic [31:0] pl_addr = '0;
    logic [7:0]  pl_data = '0;

    function automatic logic [15:0] ridx(input logic [31:0] a);
        ridx = {a[19:16], a[11:0]};
    endfunction

    always @(posedge clk) begin
        if (pl_en) ram[ridx(pl_addr)] <= pl_data;
        else if (mem_wr) ram[ridx(mem_a)] <= mem_dout;
        mem_din <= ram[ridx(mem_a)];
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, got, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [7:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        @(posedge clk);
        #1;
        pl_en = 1'b0;
    endtask

    // Scoreboard of expected completions, consumed when a done pulse is seen.
    typedef struct {
        bit          is_me;
        logic [31:0] data;
        bit          chk_data;
    } sb_t;
    sb_t sb_q[$];

    always @(negedge clk) begin
        if (if_done || me_done) begin
            sb_t e;
            if (if_done && me_done) chk("both_done", 32'd1, 32'd0);
            if (sb_q.size() == 0) begin
                chk("unexpected_done", {30'd0, me_done, if_done}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("done_owner", {31'd0, me_done}, {31'd0, e.is_me});
                if (e.chk_data) chk("done_data", me_done ? me_rdata : if_data, e.data);
            end
        end
    end

    // Requesters must hold their request fields stable until done.
    a_me_stable: assert property (@(posedge clk) disable iff (rst)
        (me_req && !me_done) |=> (me_req && $stable(me_we) && $stable(me_addr)
                                  && $stable(me_len) && $stable(me_wdata)))
        else begin
            errors++;
            $display("FAIL me_stable: request fields changed before me_done");
        end
    a_if_stable: assert property (@(posedge clk) disable iff (rst)
        (if_req && !if_done) |=> (if_req && $stable(if_addr)))
        else begin
            errors++;
            $display("FAIL if_stable: request fields changed before if_done");
        end

    typedef struct {
        bit          is_me;
        bit          we;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        int          lat;
    } vec_t;

    task automatic run_vec(input int k, input vec_t v);
        int n;
        int c;
        int c_done;
        logic dn;
        logic [7:0] wb;
        n = !v.is_me ? 4 : (v.len == 2'd0) ? 1 : (v.len == 2'd1) ? 2 : 4;
        sb_q.push_back('{v.is_me, v.exp_data, !v.we});
        @(posedge clk);
        #1;
        if (v.is_me) begin
            me_req = 1'b1; me_we = v.we; me_len = v.len; me_addr = v.addr; me_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        c      = 0;
        c_done = 0;
        while (c < 20 && c_done == 0) begin
            @(posedge clk);
            #1;
            c++;
            dn = v.is_me ? me_done : if_done;
            if (c <= n) begin
                chk($sformatf("v%0d_a%0d", k, c), mem_a, v.addr + 32'(c - 1));
                chk($sformatf("v%0d_wr%0d", k, c), {31'd0, mem_wr}, {31'd0, v.we});
                if (v.we) begin
                    wb = 8'(v.wdata >> (8 * (c - 1)));
                    chk($sformatf("v%0d_dout%0d", k, c), {24'd0, mem_dout}, {24'd0, wb});
                end
            end else begin
                chk($sformatf("v%0d_idle_port%0d", k, c), mem_a | {23'd0, mem_dout, mem_wr}, 32'd0);
            end
            if (c == v.lat - 1) begin
                chk($sformatf("v%0d_stall_hi", k),
                    {31'd0, v.is_me ? me_stall_req : if_stall_req}, 32'd1);
            end
            if (dn) begin
                c_done = c;
                chk($sformatf("v%0d_stall_lo", k),
                    {31'd0, v.is_me ? me_stall_req : if_stall_req}, 32'd0);
            end
        end
        chk($sformatf("v%0d_latency", k), 32'(c_done), 32'(v.lat));
        @(posedge clk);
        if (v.is_me) me_req = 1'b0;
        else if_req = 1'b0;
        #1;
    endtask

    // Both requesters raised in the same IDLE cycle; MEM half read at 0x2, IF fetch at 0x100.
    task automatic run_tie(input string name, input bit me_first);
        int c;
        int c_me;
        int c_if;
        bit drop_me;
        bit drop_if;
        if (me_first) begin
            sb_q.push_back('{1'b1, 32'h0000_1234, 1'b1});
            sb_q.push_back('{1'b0, 32'h9300_0013, 1'b1});
        end else begin
            sb_q.push_back('{1'b0, 32'h9300_0013, 1'b1});
            sb_q.push_back('{1'b1, 32'h0000_1234, 1'b1});
        end
        @(posedge clk);
        #1;
        me_req = 1'b1; me_we = 1'b0; me_len = 2'd1; me_addr = 32'h2; me_wdata = '0;
        if_req = 1'b1; if_addr = 32'h100;
        c = 0; c_me = 0; c_if = 0; drop_me = 0; drop_if = 0;
        while (c < 30 && (c_me == 0 || c_if == 0)) begin
            @(posedge clk);
            if (drop_me) begin me_req = 1'b0; drop_me = 0; end
            if (drop_if) begin if_req = 1'b0; drop_if = 0; end
            #1;
            c++;
            if (me_done) begin
                c_me = c; drop_me = 1;
                if (c_if == 0) chk({name, "_if_stalled"}, {31'd0, if_stall_req}, 32'd1);
            end
            if (if_done) begin
                c_if = c; drop_if = 1;
                if (c_me == 0) chk({name, "_me_stalled"}, {31'd0, me_stall_req}, 32'd1);
            end
        end
        @(posedge clk);
        if (drop_me) me_req = 1'b0;
        if (drop_if) if_req = 1'b0;
        #1;
        chk({name, "_me_cycle"}, 32'(c_me), me_first ? 32'd4 : 32'd11);
        chk({name, "_if_cycle"}, 32'(c_if), me_first ? 32'd11 : 32'd6);
    endtask

    vec_t vecs[10];
    int   strobes;

    initial begin
        vecs[0] = '{1'b0, 1'b0, 2'd0, 32'h0000_0100, 32'h0,         32'h9300_0013, 6};
        vecs[1] = '{1'b1, 1'b1, 2'd0, 32'h0003_0000, 32'h0000_0041, 32'h0,         2};
        vecs[2] = '{1'b1, 1'b0, 2'd1, 32'h0000_0002, 32'h0,         32'h0000_1234, 4};
        vecs[3] = '{1'b1, 1'b0, 2'd0, 32'h0003_0000, 32'h0,         32'h0000_0041, 3};
        vecs[4] = '{1'b1, 1'b0, 2'd3, 32'hFFFF_FFFE, 32'h0,         32'hDDCC_BBAA, 6};
        vecs[5] = '{1'b1, 1'b1, 2'd2, 32'h0000_0200, 32'hCAFE_F00D, 32'h0,         5};
        vecs[6] = '{1'b1, 1'b0, 2'd2, 32'h0000_0200, 32'h0,         32'hCAFE_F00D, 6};
        vecs[7] = '{1'b1, 1'b1, 2'd1, 32'h0000_0300, 32'h1234_5678, 32'h0,         3};
        vecs[8] = '{1'b1, 1'b0, 2'd3, 32'h0000_0300, 32'h0,         32'h0000_5678, 6};
        vecs[9] = '{1'b0, 1'b0, 2'd0, 32'hFFFF_FFFE, 32'h0,         32'hDDCC_BBAA, 6};

        rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        me_req = 1'b0; me_we = 1'b0; me_addr = '0; me_len = '0; me_wdata = '0;

        preload(32'h100, 8'h13); preload(32'h101, 8'h00);
        preload(32'h102, 8'h00); preload(32'h103, 8'h93);
        preload(32'h2, 8'h34);   preload(32'h3, 8'h12);   preload(32'h4, 8'hEE);
        preload(32'hFFFF_FFFE, 8'hAA); preload(32'hFFFF_FFFF, 8'hBB);
        preload(32'h0, 8'hCC);   preload(32'h1, 8'hDD);
        preload(32'h302, 8'h00); preload(32'h303, 8'h00);
        for (int i = 0; i < 4; i++) preload(32'h400 + 32'(i), 8'h00);

        chk("rst_ctrl", {22'd0, if_done, me_done, mem_wr, mem_dout}, 32'd0);
        chk("rst_if_data", if_data, 32'd0);
        chk("rst_me_rdata", me_rdata, 32'd0);
        chk("rst_mem_a", mem_a, 32'd0);
        if_req = 1'b1; me_req = 1'b1;
        #1;
        chk("rst_stall_follow", {30'd0, if_stall_req, me_stall_req}, 32'd3);
        if_req = 1'b0; me_req = 1'b0;
        #1;
        chk("rst_stall_drop", {30'd0, if_stall_req, me_stall_req}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int k = 0; k < 10; k++) run_vec(k, vecs[k]);

        run_tie("tie1", 1'b1);
        run_vec(10, vecs[3]);
`ifdef MEMCTRL_RR_EN
        run_tie("tie2", 1'b0);
`else
        run_tie("tie2", 1'b1);
`endif

        // Word write aborted by reset after two strobes.
        strobes = 0;
        @(posedge clk);
        #1;
        me_req = 1'b1; me_we = 1'b1; me_len = 2'd3; me_addr = 32'h400; me_wdata = 32'h4433_2211;
        @(posedge clk);
        #1;
        chk("abort_strobe1", {31'd0, mem_wr}, 32'd1);
        @(posedge clk);
        #1;
        chk("abort_strobe2", {31'd0, mem_wr}, 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_stall_in_rst", {31'd0, me_stall_req}, 32'd1);
        @(posedge clk);
        #1;
        chk("abort_ctrl", {22'd0, if_done, me_done, mem_wr, mem_dout}, 32'd0);
        chk("abort_mem_a", mem_a, 32'd0);
        me_req = 1'b0; me_we = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (mem_wr) strobes++;
        end
        rst = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (mem_wr || me_done) strobes++;
        end
        chk("abort_no_activity", 32'(strobes), 32'd0);
        chk("abort_ram", {ram[ridx(32'h403)], ram[ridx(32'h402)], ram[ridx(32'h401)],
                          ram[ridx(32'h400)]}, 32'h0000_2211);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter between instruction fetch (IF) and the memory stage (MEM) of the 5-stage pipeline. It owns the byte-wide RAM port and serialises 1/2/4-byte accesses. It returns assembled read data and a one-cycle done pulse to each requester. It raises if/me stall requests toward the stall controller while a requester's access is outstanding.

## Interface
Parameters:
- ADDR_W, 32, address width of requester and RAM address buses

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- if_req  in  1  IF read request; level, held until if_done
- if_addr  in  ADDR_W  IF fetch address (4-byte read)
- if_done  out  1  one-cycle pulse, if_data valid
- if_data  out  32  assembled instruction word
- me_req  in  1  MEM request; level, held until me_done
- me_we  in  1  1 = write, 0 = read
- me_addr  in  ADDR_W  MEM base address
- me_len  in  2  byte count minus 1: 0 = byte, 1 = half, 3 = word; 2 is illegal and treated as 3
- me_wdata  in  32  write data, byte k on bits [8k+7:8k]
- me_done  out  1  one-cycle pulse, access complete, me_rdata valid on reads
- me_rdata  out  32  read data, zero-extended; sign extension is done in MEM
- if_stall_req  out  1  combinational: if_req && !if_done
- me_stall_req  out  1  combinational: me_req && !me_done
- mem_a  out  ADDR_W  RAM byte address
- mem_dout  out  8  RAM write byte
- mem_din  in  8  RAM read byte, valid one cycle after the address is driven
- mem_wr  out  1  RAM write strobe

## Operation
- States: IDLE, RD, WR, DONE. A byte counter cnt (3 bits) and a grant register gnt (0 = IF, 1 = MEM) are kept.
- IDLE: if any request is present, the arbiter latches gnt, base address, N = len+1 (IF always N = 4), and wdata. It clears cnt and goes to RD or WR. IF requests are always reads.
- RD, cycle cnt = 0..N:
  - When cnt < N, drive mem_a = base + cnt.
  - When cnt ≥ 1, capture mem_din into byte cnt-1.
  - When cnt = N, go to DONE.
- WR, cycle cnt = 0..N-1: drive mem_a = base + cnt, mem_dout = wdata byte cnt, mem_wr = 1. At cnt = N-1, go to DONE.
- DONE: pulse the done output of the granted requester with its data. No grant is made in this cycle. The next state is IDLE.
- Requesters drop req at the edge ending their done cycle. A req still high in the following IDLE cycle is a new request.
- Address arithmetic is modulo 2^ADDR_W; wrap-around is allowed.
- Unused read-data bytes are 0.
- Outside active cycles: mem_a = 0, mem_dout = 0, mem_wr = 0.
- A requester's req, addr, len, we and wdata must be stable from request until done. The bench checks this with an assertion.

## Timing
- Reset: state IDLE, cnt 0, gnt 0. All outputs are 0: if_done, me_done, if_data, me_rdata, mem_a, mem_dout, mem_wr.
- Stall outputs follow the inputs combinationally during reset.
- Request first seen high in cycle t (IDLE):
  - N-byte read: RAM cycles t+1..t+N, captures in t+2..t+N+1, done in t+N+2. A word read has done at t+6.
  - N-byte write: strobes in t+1..t+N, done in t+N+1. A word write has done at t+5; a byte write at t+2.
- Simultaneous if_req and me_req in IDLE: MEM wins. IF stays stalled until its own done.
- A request that arrives during a busy access waits. Arbitration happens only in IDLE.
- rst asserted mid-access: abort at that edge. No further mem_wr pulses, no done pulse, and return to IDLE. Bytes already written stay written.
- rdy_in is not an input. Global pause is handled by the stall controller freezing the requesters; the arbiter keeps running.

## Configuration
- MEMCTRL_RR_EN defined:
  - Round-robin arbitration. When both requesters are present in IDLE, grant the requester not served by the previous completed access.
  - The last-served flag resets to IF, so MEM wins the first tie.
- MEMCTRL_RR_EN undefined: fixed priority, MEM over IF.

## Structure
- Shared header defines.vh holds:
  - state encodings (MaState*)
  - me_len encodings (MemLenByte/Half/Word)
  - existing StallReq/NoStallReq constants, reused for the stall outputs
- One sub-module, mem_grant: combinational winner select from if_req, me_req and the last-served flag. It implements both the fixed-priority and the round-robin policy under MEMCTRL_RR_EN.

## Test plan
- Word fetch: if_req, if_addr = 0x100, RAM bytes 13,00,00,93 → mem_a 0x100..0x103 in t+1..t+4; if_done at t+6; if_data = 0x93000013; if_stall_req high t..t+5.
- Byte write: me_req, me_we = 1, me_len = 0, me_addr = 0x30000, me_wdata = 0x41 → single mem_wr at t+1 with mem_dout = 0x41; me_done at t+2.
- Half read: me_len = 1 at 0x2 with RAM 0x34,0x12 → me_rdata = 0x00001234; done at t+4.
- Contention: if_req and me_req both high in the same IDLE cycle → MEM is served first, then IF. With MEMCTRL_RR_EN and last-served = MEM, IF is served first.
- Reset during a word write after 2 strobes → no strobes afterwards, no me_done, all outputs 0.
- Wrap-around: word read at 0xFFFFFFFE → mem_a sequence FFFFFFFE, FFFFFFFF, 0, 1.
